mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous modulo-N up/down counter. It adds these features to the fixed 4-bit up-only counters:
- configurable width and modulus
- run-time direction control
- synchronous clear and parallel load
- wrap or saturate mode
- a combinational terminal-count output for cascading
- a sticky overflow flag

It is the general-purpose counter for timers, dividers and event counters in the design.

## Interface
- WIDTH, 4: counter width in bits; 1 ≤ WIDTH ≤ 32.
- MODULUS, 16: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.
- PRESCALE_W, 8: prescaler divider width. Present only with COUNTER_PRESCALE_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high; clock clk.
- clr  in  1  synchronous clear of q and ovf.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- div  in  PRESCALE_W  prescale divider (only with COUNTER_PRESCALE_EN).
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational.
- ovf  out  1  sticky overflow/underflow flag, registered.

## Operation
- tick = en AND prescaler strobe. Without the macro, tick = en.
- Priority per rising edge: rst > clr > load > tick.
  - rst (async): q=0, ovf=0, prescaler=0.
  - clr: q=0, ovf=0, prescaler=0.
  - load: q = load_val if load_val < MODULUS, otherwise MODULUS-1. ovf unchanged. Prescaler restarts at 0.
  - tick, up=1:
    - q < MODULUS-1: q+1.
    - q == MODULUS-1: q=0 (SATURATE=0) or hold (SATURATE=1); ovf=1.
  - tick, up=0:
    - q > 0: q-1.
    - q == 0: q=MODULUS-1 (SATURATE=0) or hold (SATURATE=1); ovf=1.
  - no tick: hold.
- tc = tick AND ((up AND q==MODULUS-1) OR (!up AND q==0)). It is purely combinational and asserts in the cycle before the wrap edge. Cascade by tying a downstream stage's en to the upstream tc.
- Arithmetic is internally WIDTH+1 bits, with no truncation artefacts. When MODULUS = 2^WIDTH the clamp on load is never active.
- Direction may change on any cycle; it takes effect on the next tick.

## Timing
- Latency: one clk from a qualifying input to q/ovf. tc has zero latency from en, up, q and the prescaler strobe.
- Reset values: q=0, ovf=0, tc=0.
- rst asserted mid-count clears state immediately and asynchronously. Deassertion must be synchronous to clk; this is the integrator's responsibility.
- clr and load on the same edge: clr wins. load and tick on the same edge: the load value is taken and tick is ignored.

## Configuration
COUNTER_PRESCALE_EN:
- Defined: adds the PRESCALE_W parameter, the div port and a PRESCALE_W-bit prescaler.
  - The prescaler counts only en cycles.
  - The strobe is high on the en cycle where prescaler == div; the prescaler then returns to 0.
  - div=0 gives a tick on every en cycle; div=N gives one tick per N+1 en cycles.
  - div is sampled live. If the prescaler is already above div, the strobe fires on the next en cycle.
- Undefined: no prescaler logic and no div port; tick = en.

## Structure
- Shared package counter_pkg: the counter mode constants (CNT_WRAP=0, CNT_SAT=1) and the legality checks WIDTH/MODULUS, which fire an elaboration error on illegal values.
- One sub-module, cnt_prescaler (enable-strobe generator), instantiated only under COUNTER_PRESCALE_EN.
- The top level holds the count register, next-state mux, clamp, tc and ovf logic.

## Test plan
- Wrap: WIDTH=4, MODULUS=10, up=1, en=1 from reset, 12 cycles.
  - Expect q 0..9,0,1.
  - tc high exactly while q=9.
  - ovf set on the 9→0 edge and stays set.
- Down and saturate: SATURATE=1, load_val=2, up=0, en=1, 4 cycles.
  - Expect q 2,1,0,0,0; ovf=1 after the first hold.
  - tc high while q=0.
- Load clamp and priority: MODULUS=10.
  - load_val=13 gives q=9.
  - clr+load on the same edge gives q=0, ovf=0.
  - load+en with load_val=4 gives q=4, not 5.
- Async reset mid-count: assert rst between edges while q=7. q=0 and ovf=0 immediately, with no clock edge required.
- Cascade: two instances, MODULUS=10, with the second stage's en = first stage's tc. After 100 en cycles the pair reads 0,0, and the second stage's ovf is set once.
- Prescaler (macro defined): div=3, en=1 continuous. q increments every 4th cycle; 8 cycles give q=2. Toggling en low pauses the prescaler.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode constants and parameter legality checks for the
// general-purpose up/down counter family.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  function automatic bit width_legal(input int width);
    return (width >= 1) && (width <= 32);
  endfunction

  // MODULUS may be as large as 2^WIDTH, which needs more than 32 bits when WIDTH=32
  function automatic bit modulus_legal(input int width, input longint unsigned modulus);
    return (modulus >= 64'd2) && (modulus <= (64'd1 << width));
  endfunction

  function automatic bit mode_legal(input int mode);
    return (mode == CNT_WRAP) || (mode == CNT_SAT);
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: enable-strobe generator for mod_updown_counter.
// Only built when COUNTER_PRESCALE_EN is defined; otherwise this file is empty.
`ifdef COUNTER_PRESCALE_EN
module cnt_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         strobe
);

  logic [W-1:0] cnt_r;

  // >= rather than == so that lowering div below the current count fires on the next en cycle
  assign strobe = en && (cnt_r >= div);

  // count en cycles, fold back to zero on the strobe or on a counter clear/load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= strobe ? '0 : cnt_r + W'(1);
    end
  end

endmodule
`endif

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised modulo-N up/down counter with clear, load
// (clamped to MODULUS-1), wrap/saturate mode, combinational terminal count and
// sticky overflow. Defining COUNTER_PRESCALE_EN adds the div port and an
// enable prescaler (cnt_prescaler).
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = CNT_WRAP
`ifdef COUNTER_PRESCALE_EN
  , parameter int            PRESCALE_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] div,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("mod_updown_counter: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS=%0d outside 2..2^WIDTH", MODULUS);
  end
  if (!mode_legal(SATURATE)) begin : g_bad_mode
    $error("mod_updown_counter: SATURATE=%0d must be 0 or 1", SATURATE);
  end

  // Count is held one bit wider than q so MODULUS=2^WIDTH compares and clamps exactly;
  // the extra bit is always zero and is pruned by synthesis.
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MODULUS - 64'd1);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam bit             SAT_MODE = (SATURATE == CNT_SAT);

  logic [WIDTH:0] cnt_r;
  logic [WIDTH:0] cnt_nxt;
  logic [WIDTH:0] cnt_inc;
  logic [WIDTH:0] cnt_dec;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] load_clamped;
  logic           ovf_r;
  logic           ovf_nxt;
  logic           tick;
  logic           at_max;
  logic           at_zero;

`ifdef COUNTER_PRESCALE_EN
  logic pre_strobe;

  cnt_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (clr | load),
    .en      (en),
    .div     (div),
    .strobe  (pre_strobe)
  );

  assign tick = pre_strobe;
`else
  assign tick = en;
`endif

  assign load_ext     = {1'b0, load_val};
  assign load_clamped = (load_ext < MOD_EXT) ? load_ext : MAX_EXT;
  assign cnt_inc      = cnt_r + ONE_EXT;
  assign cnt_dec      = cnt_r - ONE_EXT;
  assign at_max       = (cnt_r == MAX_EXT);
  assign at_zero      = (cnt_r == '0);

  // next-state mux: clr > load > tick > hold
  always_comb begin
    cnt_nxt = cnt_r;
    ovf_nxt = ovf_r;
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      cnt_nxt = load_clamped;
    end else if (tick) begin
      if (up) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SAT_MODE ? cnt_r : '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end else begin
        if (at_zero) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SAT_MODE ? cnt_r : MAX_EXT;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
    end
  end

  // count and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign q   = cnt_r[WIDTH-1:0];
  assign ovf = ovf_r;
  assign tc  = tick && ((up && at_max) || (!up && at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench for mod_updown_counter covering wrap,
// saturate, load clamp/priority, async reset, full-range modulus, cascade and
// (when COUNTER_PRESCALE_EN is defined) the prescaler.
module tb_mod_updown_counter;

  typedef struct {
    string tag;
    int    q;
    bit    ovf;
  } exp_t;

  typedef struct {
    bit clr;
    bit load;
    int lv;
    bit en;
    bit up;
  } stim_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // wrap instance, MODULUS=10
  logic       w_clr, w_load, w_en, w_up, w_tc, w_ovf;
  logic [3:0] w_load_val, w_q;
  // saturate instance, MODULUS=10
  logic       s_clr, s_load, s_en, s_up, s_tc, s_ovf;
  logic [3:0] s_load_val, s_q;
  // full-range instance, MODULUS=16
  logic       f_clr, f_load, f_en, f_up, f_tc, f_ovf;
  logic [3:0] f_load_val, f_q;
  // cascade pair
  logic       c_clr, c_en, c0_tc, c0_ovf, c1_tc, c1_ovf;
  logic [3:0] c0_q, c1_q;

`ifdef COUNTER_PRESCALE_EN
  logic [7:0] zero_div;
  logic       p_clr, p_load, p_en, p_up, p_tc, p_ovf;
  logic [3:0] p_load_val, p_q;
  logic [7:0] p_div;
`endif

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_w (
    .clk(clk), .rst(rst), .clr(w_clr), .load(w_load), .load_val(w_load_val),
    .en(w_en), .up(w_up),
`ifdef COUNTER_PRESCALE_EN
    .div(zero_div),
`endif
    .q(w_q), .tc(w_tc), .ovf(w_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
    .clk(clk), .rst(rst), .clr(s_clr), .load(s_load), .load_val(s_load_val),
    .en(s_en), .up(s_up),
`ifdef COUNTER_PRESCALE_EN
    .div(zero_div),
`endif
    .q(s_q), .tc(s_tc), .ovf(s_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_f (
    .clk(clk), .rst(rst), .clr(f_clr), .load(f_load), .load_val(f_load_val),
    .en(f_en), .up(f_up),
`ifdef COUNTER_PRESCALE_EN
    .div(zero_div),
`endif
    .q(f_q), .tc(f_tc), .ovf(f_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c0 (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up(1'b1),
`ifdef COUNTER_PRESCALE_EN
    .div(zero_div),
`endif
    .q(c0_q), .tc(c0_tc), .ovf(c0_ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c1 (
    .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(4'd0),
    .en(c0_tc), .up(1'b1),
`ifdef COUNTER_PRESCALE_EN
    .div(zero_div),
`endif
    .q(c1_q), .tc(c1_tc), .ovf(c1_ovf));

`ifdef COUNTER_PRESCALE_EN
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE_W(8)) u_p (
    .clk(clk), .rst(rst), .clr(p_clr), .load(p_load), .load_val(p_load_val),
    .en(p_en), .up(p_up), .div(p_div),
    .q(p_q), .tc(p_tc), .ovf(p_ovf));
`endif

  // reference behaviour of one counter for one clock edge (tick = en)
  function automatic void model_step(input int modv, input bit sat, input stim_t r,
                                     inout int mq, inout bit movf);
    if (r.clr) begin
      mq = 0;
      movf = 1'b0;
    end else if (r.load) begin
      mq = (r.lv < modv) ? r.lv : modv - 1;
    end else if (r.en) begin
      if (r.up) begin
        if (mq == modv - 1) begin
          movf = 1'b1;
          if (!sat) mq = 0;
        end else mq = mq + 1;
      end else begin
        if (mq == 0) begin
          movf = 1'b1;
          if (!sat) mq = modv - 1;
        end else mq = mq - 1;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    w_clr = 0; w_load = 0; w_load_val = 0; w_en = 0; w_up = 0;
    s_clr = 0; s_load = 0; s_load_val = 0; s_en = 0; s_up = 0;
    f_clr = 0; f_load = 0; f_load_val = 0; f_en = 0; f_up = 0;
    c_clr = 0; c_en = 0;
`ifdef COUNTER_PRESCALE_EN
    zero_div = '0;
    p_clr = 0; p_load = 0; p_load_val = 0; p_en = 0; p_up = 0; p_div = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (w_q !== 4'd0)  begin n_fail++; $display("FAIL reset_q: got %0d expected 0", w_q); end
    if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", w_ovf); end
    if (w_tc !== 1'b0)  begin n_fail++; $display("FAIL reset_tc: got %0b expected 0", w_tc); end
    if (s_q !== 4'd0)  begin n_fail++; $display("FAIL reset_sat_q: got %0d expected 0", s_q); end
    if (c1_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_c1_ovf: got %0b expected 0", c1_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    int   mq = 0;
    bit   movf = 1'b0;
    bit   exp_tc;
    exp_t e;
    stim_t r;
    r = '{clr: 1'b0, load: 1'b0, lv: 0, en: 1'b1, up: 1'b1};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      w_en = 1'b1; w_up = 1'b1;
      #1;
      exp_tc = (i % 10 == 9);
      n_checks += 2;
      if (int'(w_q) !== i % 10) begin n_fail++; $display("FAIL wrap_seq[%0d]: got %0d expected %0d", i, w_q, i % 10); end
      if (w_tc !== exp_tc) begin n_fail++; $display("FAIL wrap_tc[%0d]: got %0b expected %0b", i, w_tc, exp_tc); end
      model_step(10, 1'b0, r, mq, movf);
      e.tag = "wrap"; e.q = mq; e.ovf = movf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 2;
      if (int'(w_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, w_q, e.q); end
      if (w_ovf !== e.ovf) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0b expected %0b", e.tag, i, w_ovf, e.ovf); end
    end
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic test_down_saturate();
    stim_t rows[10] = '{
      '{1, 0, 0, 0, 0}, '{0, 1, 2, 0, 0},
      '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
      '{0, 1, 9, 0, 1}, '{0, 0, 0, 1, 1}, '{0, 0, 0, 1, 1}, '{1, 0, 0, 1, 1}};
    int   mq = 0;
    bit   movf = 1'b0;
    bit   exp_tc;
    exp_t e;
    foreach (rows[i]) begin
      @(negedge clk);
      s_clr = rows[i].clr; s_load = rows[i].load; s_load_val = 4'(rows[i].lv);
      s_en = rows[i].en; s_up = rows[i].up;
      #1;
      exp_tc = rows[i].en && (rows[i].up ? (mq == 9) : (mq == 0));
      n_checks++;
      if (s_tc !== exp_tc) begin n_fail++; $display("FAIL sat_tc[%0d]: got %0b expected %0b", i, s_tc, exp_tc); end
      model_step(10, 1'b1, rows[i], mq, movf);
      e.tag = "sat"; e.q = mq; e.ovf = movf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 2;
      if (int'(s_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, s_q, e.q); end
      if (s_ovf !== e.ovf) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0b expected %0b", e.tag, i, s_ovf, e.ovf); end
      if (i == 5) begin
        n_checks += 2;
        if (s_q !== 4'd0) begin n_fail++; $display("FAIL sat_floor_q: got %0d expected 0", s_q); end
        if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_floor_ovf: got %0b expected 1", s_ovf); end
      end
    end
    @(negedge clk);
    s_clr = 0; s_en = 0;
  endtask

  task automatic test_load_clamp();
    stim_t rows[10] = '{
      '{1, 0, 0, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 0, 0, 1, 1},
      '{0, 1, 13, 0, 0}, '{0, 1, 10, 0, 0}, '{1, 1, 5, 0, 0},
      '{0, 1, 4, 1, 1}, '{0, 0, 0, 1, 1}, '{0, 1, 9, 0, 1}, '{1, 0, 0, 1, 1}};
    int   mq = 0;
    bit   movf = 1'b0;
    bit   exp_tc;
    exp_t e;
    foreach (rows[i]) begin
      @(negedge clk);
      w_clr = rows[i].clr; w_load = rows[i].load; w_load_val = 4'(rows[i].lv);
      w_en = rows[i].en; w_up = rows[i].up;
      #1;
      exp_tc = rows[i].en && (rows[i].up ? (mq == 9) : (mq == 0));
      n_checks++;
      if (w_tc !== exp_tc) begin n_fail++; $display("FAIL load_tc[%0d]: got %0b expected %0b", i, w_tc, exp_tc); end
      model_step(10, 1'b0, rows[i], mq, movf);
      e.tag = "load"; e.q = mq; e.ovf = movf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 2;
      if (int'(w_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, w_q, e.q); end
      if (w_ovf !== e.ovf) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0b expected %0b", e.tag, i, w_ovf, e.ovf); end
    end
    @(negedge clk);
    w_clr = 0; w_load = 0; w_en = 0;
  endtask

  task automatic test_async_reset();
    stim_t r;
    int   mq = 0;
    bit   movf = 1'b0;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0)      r = '{clr: 1, load: 0, lv: 0, en: 0, up: 1};
      else if (i == 1) r = '{clr: 0, load: 1, lv: 9, en: 0, up: 1};
      else             r = '{clr: 0, load: 0, lv: 0, en: 1, up: 1};
      w_clr = r.clr; w_load = r.load; w_load_val = 4'(r.lv); w_en = r.en; w_up = r.up;
      model_step(10, 1'b0, r, mq, movf);
      e.tag = "arst_pre"; e.q = mq; e.ovf = movf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 2;
      if (int'(w_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, w_q, e.q); end
      if (w_ovf !== e.ovf) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0b expected %0b", e.tag, i, w_ovf, e.ovf); end
    end
    @(negedge clk);
    w_en = 0;
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (w_q !== 4'd0) begin n_fail++; $display("FAIL arst_q: got %0d expected 0", w_q); end
    if (w_ovf !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %0b expected 0", w_ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_range();
    stim_t rows[7] = '{
      '{1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 1},
      '{0, 1, 15, 0, 0}, '{0, 0, 0, 1, 1}, '{1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0}};
    int   mq = 0;
    bit   movf = 1'b0;
    bit   exp_tc;
    exp_t e;
    foreach (rows[i]) begin
      @(negedge clk);
      f_clr = rows[i].clr; f_load = rows[i].load; f_load_val = 4'(rows[i].lv);
      f_en = rows[i].en; f_up = rows[i].up;
      #1;
      exp_tc = rows[i].en && (rows[i].up ? (mq == 15) : (mq == 0));
      n_checks++;
      if (f_tc !== exp_tc) begin n_fail++; $display("FAIL full_tc[%0d]: got %0b expected %0b", i, f_tc, exp_tc); end
      model_step(16, 1'b0, rows[i], mq, movf);
      e.tag = "full"; e.q = mq; e.ovf = movf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 2;
      if (int'(f_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, f_q, e.q); end
      if (f_ovf !== e.ovf) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0b expected %0b", e.tag, i, f_ovf, e.ovf); end
    end
    @(negedge clk);
    f_clr = 0; f_load = 0; f_en = 0;
  endtask

  task automatic test_cascade();
    int    m0 = 0, m1 = 0;
    bit    o0 = 1'b0, o1 = 1'b0;
    bit    exp_tc;
    stim_t r0, r1;
    exp_t  e;
    @(negedge clk);
    c_clr = 1'b1; c_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    c_clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      c_en = 1'b1;
      #1;
      exp_tc = (m0 == 9);
      n_checks++;
      if (c0_tc !== exp_tc) begin n_fail++; $display("FAIL casc_tc[%0d]: got %0b expected %0b", i, c0_tc, exp_tc); end
      r0 = '{clr: 0, load: 0, lv: 0, en: 1, up: 1};
      r1 = '{clr: 0, load: 0, lv: 0, en: exp_tc, up: 1};
      model_step(10, 1'b0, r0, m0, o0);
      model_step(10, 1'b0, r1, m1, o1);
      e.tag = "casc0"; e.q = m0; e.ovf = o0; sb.push_back(e);
      e.tag = "casc1"; e.q = m1; e.ovf = o1; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (int'(c0_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, c0_q, e.q); end
      e = sb.pop_front();
      n_checks += 2;
      if (int'(c1_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, c1_q, e.q); end
      if (c1_ovf !== e.ovf) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0b expected %0b", e.tag, i, c1_ovf, e.ovf); end
    end
    @(negedge clk);
    c_en = 1'b0;
    n_checks += 4;
    if (c0_q !== 4'd0) begin n_fail++; $display("FAIL casc_final_q0: got %0d expected 0", c0_q); end
    if (c1_q !== 4'd0) begin n_fail++; $display("FAIL casc_final_q1: got %0d expected 0", c1_q); end
    if (c1_ovf !== 1'b1) begin n_fail++; $display("FAIL casc_final_ovf1: got %0b expected 1", c1_ovf); end
    if (c0_ovf !== 1'b1) begin n_fail++; $display("FAIL casc_final_ovf0: got %0b expected 1", c0_ovf); end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescaler();
    int    en_seq[18]  = '{1,1,1,1,1,1,1,1, 0,0,0, 1,1,1,1, 1,1, 1};
    int    div_seq[18] = '{3,3,3,3,3,3,3,3, 3,3,3, 3,3,3,3, 3,3, 1};
    int    mq = 0, pcnt = 0;
    bit    movf = 1'b0;
    bit    tick;
    stim_t r;
    exp_t  e;
    @(negedge clk);
    p_clr = 1'b1; p_en = 1'b0; p_up = 1'b1; p_div = 8'd3;
    @(posedge clk);
    @(negedge clk);
    p_clr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      p_en = en_seq[i][0]; p_div = 8'(div_seq[i]);
      tick = (en_seq[i] != 0) && (pcnt >= div_seq[i]);
      if (en_seq[i] != 0) pcnt = tick ? 0 : pcnt + 1;
      r = '{clr: 0, load: 0, lv: 0, en: tick, up: 1};
      model_step(10, 1'b0, r, mq, movf);
      e.tag = "pre"; e.q = mq; e.ovf = movf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (int'(p_q) !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", e.tag, i, p_q, e.q); end
      if (i == 7) begin
        n_checks++;
        if (p_q !== 4'd2) begin n_fail++; $display("FAIL pre_8cyc_q: got %0d expected 2", p_q); end
      end
    end
    @(negedge clk);
    p_en = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_down_saturate();
    test_load_clamp();
    test_async_reset();
    test_full_range();
    test_cascade();
`ifdef COUNTER_PRESCALE_EN
    test_prescaler();
`endif
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
